pleiads_rom_loader: RTL and testbench

- Sequences the ROM download stream from hps_io (ioctl_*) into the Pleiads/Phoenix core's ROM and PROM regions.
- Decodes each download byte to a region write strobe with a region-local address.
- Owns the core reset: holds the core in reset during and after download, and releases it only after a complete, valid image plus a settle delay.
- Sits between hps_io and the phoenix core in the emu top level, in the clk_sys domain.

---
 rtl/pleiads_rom_loader_if.sv | 28 ++
 rtl/pleiads_rom_loader.sv | 253 +++++++++++++++++++++++++
 tb/tb_pleiads_rom_loader.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pleiads_rom_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : pleiads_rom_loader_if
// Description : ioctl download bus from hps_io into the Pleiads ROM loader.
//               The master drives the byte stream, the loader is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface pleiads_rom_loader_if;
    logic        dn_download;   // ioctl_download level
    logic        dn_wr;         // ioctl_wr byte strobe
    logic [15:0] dn_addr;       // ioctl_addr[15:0]
    logic [7:0]  dn_data;       // ioctl_dout

    modport master (
        output dn_download,
        output dn_wr,
        output dn_addr,
        output dn_data
    );

    modport slave (
        input  dn_download,
        input  dn_wr,
        input  dn_addr,
        input  dn_data
    );
endinterface
`default_nettype wire

// File: rtl/pleiads_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : pleiads_rom_loader
// Description : Steers the hps_io ROM download stream into the Pleiads/Phoenix
//               program, character and colour PROM regions, and owns the core
//               reset: the core is released only after a complete, error-free
//               image followed by HOLD_CYCLES of settle time.
//               Optional macro PLEIADS_ROM_LOADER_CHECKSUM_EN adds a 16-bit
//               wrapping byte sum (checksum_o) that must equal EXPECTED_SUM
//               for the image to be accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module pleiads_rom_loader #(
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
    parameter logic [15:0] EXPECTED_SUM = 16'h0000,
`endif
    parameter logic [15:0] PROG_BASE   = 16'h0000,
    parameter int          PROG_SIZE   = 16384,
    parameter logic [15:0] CHAR1_BASE  = 16'h4000,
    parameter int          CHAR1_SIZE  = 4096,
    parameter logic [15:0] CHAR2_BASE  = 16'h5000,
    parameter int          CHAR2_SIZE  = 4096,
    parameter logic [15:0] PROM_BASE   = 16'h6000,
    parameter int          PROM_SIZE   = 512,
    parameter int          HOLD_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    pleiads_rom_loader_if.slave        dn_if,
    input  logic                       ext_reset_i,
    output logic [13:0]                wr_addr_o,
    output logic [7:0]                 wr_data_o,
    output logic                       prog_we_o,
    output logic                       char1_we_o,
    output logic                       char2_we_o,
    output logic                       prom_we_o,
    output logic                       core_reset_o,
    output logic                       dl_done_o,
    output logic                       dl_error_o,
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
    output logic [15:0]                checksum_o,
`endif
    output logic [16:0]                byte_count_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          c_total_int = PROG_SIZE + CHAR1_SIZE + CHAR2_SIZE + PROM_SIZE;
    localparam logic [16:0] c_total     = 17'(c_total_int);
    localparam int          c_hold_w    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_hold_w-1:0] c_hold_init = c_hold_w'(HOLD_CYCLES - 1);

    // Region index 0..3 = program, background chars, foreground chars, PROMs;
    // the same order as the write-strobe vector.
    localparam logic [31:0] c_region_base [4] = '{32'(PROG_BASE), 32'(CHAR1_BASE),
                                                  32'(CHAR2_BASE), 32'(PROM_BASE)};
    localparam logic [31:0] c_region_size [4] = '{32'(PROG_SIZE), 32'(CHAR1_SIZE),
                                                  32'(CHAR2_SIZE), 32'(PROM_SIZE)};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              state_q,      state_d;
    logic                dl_prev_q;
    logic [3:0]          we_q,         we_d;
    logic [13:0]         wr_addr_q,    wr_addr_d;
    logic [7:0]          wr_data_q,    wr_data_d;
    logic                core_reset_q, core_reset_d;
    logic                dl_done_q,    dl_done_d;
    logic                dl_error_q,   dl_error_d;
    logic [16:0]         byte_count_q, byte_count_d;
    logic [c_hold_w-1:0] hold_q,       hold_d;
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
    logic [15:0]         checksum_q,   checksum_d;
`endif

    logic                w_rise;
    logic                w_fall;
    logic                w_image_ok;
    logic [31:0]         w_off [4];
    logic [3:0]          w_hit;
    logic [13:0]         w_local;

    assign w_rise = dn_if.dn_download & ~dl_prev_q;
    assign w_fall = ~dn_if.dn_download & dl_prev_q;

    // ------------------------------------------------------------------------
    // Region decode: the unsigned offset wraps to a huge value below the
    // base, so a single "offset < size" compare covers both bounds.
    // ------------------------------------------------------------------------
    for (genvar r = 0; r < 4; r++) begin : g_region
        assign w_off[r] = {16'h0000, dn_if.dn_addr} - c_region_base[r];
        assign w_hit[r] = (w_off[r] < c_region_size[r]);
    end

    // Region-local address of whichever region the byte falls into
    always_comb begin
        w_local = '0;
        for (int r = 0; r < 4; r++) begin
            if (w_hit[r]) begin
                w_local = w_off[r][13:0];
            end
        end
    end

    // Next-state, strobe and reset-control logic
    always_comb begin
        state_d      = state_q;
        we_d         = '0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        core_reset_d = core_reset_q;
        dl_done_d    = dl_done_q;
        dl_error_d   = dl_error_q;
        byte_count_d = byte_count_q;
        hold_d       = hold_q;
        w_image_ok   = 1'b0;
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif

        case (state_q)
            S_IDLE: begin
                core_reset_d = 1'b1;
            end

            S_LOAD: begin
                if (dn_if.dn_wr) begin
                    if (|w_hit) begin
                        we_d      = w_hit;
                        wr_addr_d = w_local;
                        wr_data_d = dn_if.dn_data;
                        if (byte_count_q != 17'h1FFFF) begin
                            byte_count_d = byte_count_q + 17'd1;
                        end
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
                        checksum_d = checksum_q + {8'h00, dn_if.dn_data};
`endif
                    end else begin
                        dl_error_d = 1'b1;
                    end
                end

                // Judge the image on the next-state values so that a byte
                // arriving together with the falling edge is included.
                w_image_ok = (byte_count_d == c_total) && !dl_error_d;
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
                w_image_ok = w_image_ok && (checksum_d == EXPECTED_SUM);
`endif
                if (w_fall) begin
                    if (w_image_ok) begin
                        state_d = S_HOLD;
                        hold_d  = c_hold_init;
                    end else begin
                        state_d    = S_IDLE;
                        dl_error_d = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (hold_q == '0) begin
                    state_d      = S_RUN;
                    dl_done_d    = 1'b1;
                    core_reset_d = 1'b0;
                end else begin
                    hold_d = hold_q - c_hold_w'(1);
                end
            end

            S_RUN: begin
                core_reset_d = ext_reset_i;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new download restarts everything from any state
        if (w_rise) begin
            state_d      = S_LOAD;
            byte_count_d = '0;
            dl_done_d    = 1'b0;
            dl_error_d   = 1'b0;
            core_reset_d = 1'b1;
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
            checksum_d   = '0;
`endif
        end
    end

    // State register; dl_prev resets high so a download level still present
    // when reset is released is not mistaken for a fresh rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            dl_prev_q    <= 1'b1;
            we_q         <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            core_reset_q <= 1'b1;
            dl_done_q    <= 1'b0;
            dl_error_q   <= 1'b0;
            byte_count_q <= '0;
            hold_q       <= '0;
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            dl_prev_q    <= dn_if.dn_download;
            we_q         <= we_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            core_reset_q <= core_reset_d;
            dl_done_q    <= dl_done_d;
            dl_error_q   <= dl_error_d;
            byte_count_q <= byte_count_d;
            hold_q       <= hold_d;
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign prog_we_o    = we_q[0];
    assign char1_we_o   = we_q[1];
    assign char2_we_o   = we_q[2];
    assign prom_we_o    = we_q[3];
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign core_reset_o = core_reset_q;
    assign dl_done_o    = dl_done_q;
    assign dl_error_o   = dl_error_q;
    assign byte_count_o = byte_count_q;
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
    assign checksum_o   = checksum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pleiads_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pleiads_rom_loader
// Description : Self-checking bench for pleiads_rom_loader. Downloads full,
//               short, out-of-map and interrupted images and compares the
//               strobes, counters and reset control against an address-map
//               reference model. Honours PLEIADS_ROM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pleiads_rom_loader;

    localparam logic [15:0] PROG_BASE   = 16'h0000;
    localparam int          PROG_SIZE   = 16384;
    localparam logic [15:0] CHAR1_BASE  = 16'h4000;
    localparam int          CHAR1_SIZE  = 4096;
    localparam logic [15:0] CHAR2_BASE  = 16'h5000;
    localparam int          CHAR2_SIZE  = 4096;
    localparam logic [15:0] PROM_BASE   = 16'h6000;
    localparam int          PROM_SIZE   = 512;
    localparam int          HOLD_CYCLES = 1024;
    localparam int          TOTAL       = 25088;     // 0x6200
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
    // Sum of addr[7:0] over 0x0000..0x61FF: 98 * 32640 mod 65536
    localparam logic [15:0] EXP_SUM_FULL = 16'hCF00;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ext_reset;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic        prog_we, char1_we, char2_we, prom_we;
    logic        core_reset, dl_done, dl_error;
    logic [16:0] byte_count;
    logic [3:0]  we_bus;
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pleiads_rom_loader_if dn_if ();

    assign we_bus = {prom_we, char2_we, char1_we, prog_we};

    pleiads_rom_loader #(
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
        .EXPECTED_SUM (EXP_SUM_FULL),
`endif
        .PROG_BASE    (PROG_BASE),
        .PROG_SIZE    (PROG_SIZE),
        .CHAR1_BASE   (CHAR1_BASE),
        .CHAR1_SIZE   (CHAR1_SIZE),
        .CHAR2_BASE   (CHAR2_BASE),
        .CHAR2_SIZE   (CHAR2_SIZE),
        .PROM_BASE    (PROM_BASE),
        .PROM_SIZE    (PROM_SIZE),
        .HOLD_CYCLES  (HOLD_CYCLES)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dn_if        (dn_if),
        .ext_reset_i  (ext_reset),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .prog_we_o    (prog_we),
        .char1_we_o   (char1_we),
        .char2_we_o   (char2_we),
        .prom_we_o    (prom_we),
        .core_reset_o (core_reset),
        .dl_done_o    (dl_done),
        .dl_error_o   (dl_error),
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
        .checksum_o   (checksum),
`endif
        .byte_count_o (byte_count)
    );

    // ---------------- reference model: the ROM address map ----------------
    function automatic logic [3:0] ref_region(input logic [15:0] a);
        int ai;
        ai = int'(a);
        if (ai >= int'(PROG_BASE)  && ai < int'(PROG_BASE)  + PROG_SIZE)  return 4'b0001;
        if (ai >= int'(CHAR1_BASE) && ai < int'(CHAR1_BASE) + CHAR1_SIZE) return 4'b0010;
        if (ai >= int'(CHAR2_BASE) && ai < int'(CHAR2_BASE) + CHAR2_SIZE) return 4'b0100;
        if (ai >= int'(PROM_BASE)  && ai < int'(PROM_BASE)  + PROM_SIZE)  return 4'b1000;
        return 4'b0000;
    endfunction

    function automatic logic [13:0] ref_local(input logic [15:0] a);
        int ai;
        ai = int'(a);
        if (ai >= int'(PROM_BASE))  return 14'(ai - int'(PROM_BASE));
        if (ai >= int'(CHAR2_BASE)) return 14'(ai - int'(CHAR2_BASE));
        if (ai >= int'(CHAR1_BASE)) return 14'(ai - int'(CHAR1_BASE));
        return 14'(ai - int'(PROG_BASE));
    endfunction

    // One dn_wr cycle; outputs are stable on return (1 time unit after edge)
    task automatic drive_byte(input logic [15:0] a, input logic [7:0] d);
        dn_if.dn_wr   = 1'b1;
        dn_if.dn_addr = a;
        dn_if.dn_data = d;
        @(posedge clk); #1;
        dn_if.dn_wr   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ext_reset = 1'b0;
        dn_if.dn_download = 1'b0; dn_if.dn_wr = 1'b0;
        dn_if.dn_addr = '0; dn_if.dn_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (we_bus !== 4'b0 || wr_addr !== 14'd0 || wr_data !== 8'd0 || core_reset !== 1'b1 ||
            dl_done !== 1'b0 || dl_error !== 1'b0 || byte_count !== 17'd0)
            $display("FAIL reset_values: we=%b wa=%h wd=%h rst=%b done=%b err=%b cnt=%0d, expected all 0 with rst=1",
                     we_bus, wr_addr, wr_data, core_reset, dl_done, dl_error, byte_count);
        else n_pass++;
        reset_n = 1'b1;
        // Writes while idle must be ignored
        for (int i = 0; i < 4; i++) begin
            drive_byte(16'($urandom_range(0, TOTAL - 1)), 8'($urandom));
            n_checks++;
            if (we_bus !== 4'b0 || byte_count !== 17'd0 || core_reset !== 1'b1)
                $display("FAIL idle_write_ignored: we=%b cnt=%0d rst=%b, expected we=0 cnt=0 rst=1",
                         we_bus, byte_count, core_reset);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_download();
        int exp_count; logic [3:0] exp_we; logic [15:0] a; logic [7:0] d;
        exp_count = 0;
        dn_if.dn_download = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            a = 16'($urandom_range(0, TOTAL - 1)); d = 8'($urandom);
            exp_we = ref_region(a);
            exp_count++;
            drive_byte(a, d);
            n_checks++;
            if (we_bus !== exp_we || wr_addr !== ref_local(a) || wr_data !== d || byte_count !== 17'(exp_count))
                $display("FAIL mid_byte a=%h: we=%b wa=%h wd=%h cnt=%0d, expected we=%b wa=%h wd=%h cnt=%0d",
                         a, we_bus, wr_addr, wr_data, byte_count, exp_we, ref_local(a), d, exp_count);
            else n_pass++;
        end
        // Byte 100 collides with an asynchronous reset
        dn_if.dn_wr = 1'b1; dn_if.dn_addr = 16'h0010; dn_if.dn_data = 8'hA5;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (we_bus !== 4'b0 || byte_count !== 17'd0 || core_reset !== 1'b1 || dl_error !== 1'b0 ||
            wr_addr !== 14'd0 || wr_data !== 8'd0)
            $display("FAIL async_reset: we=%b cnt=%0d rst=%b err=%b wa=%h wd=%h, expected 0/0/1/0/0/0",
                     we_bus, byte_count, core_reset, dl_error, wr_addr, wr_data);
        else n_pass++;
        dn_if.dn_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_byte(16'($urandom_range(0, TOTAL - 1)), 8'($urandom));
            n_checks++;
            if (we_bus !== 4'b0 || byte_count !== 17'd0)
                $display("FAIL post_reset_write: we=%b cnt=%0d, expected we=0 cnt=0", we_bus, byte_count);
            else n_pass++;
        end
        dn_if.dn_download = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (core_reset !== 1'b1 || dl_done !== 1'b0 || dl_error !== 1'b0)
            $display("FAIL post_reset_fall: rst=%b done=%b err=%b, expected rst=1 done=0 err=0",
                     core_reset, dl_done, dl_error);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive_byte(16'($urandom_range(0, TOTAL - 1)), 8'($urandom));
            n_checks++;
            if (we_bus !== 4'b0 || core_reset !== 1'b1)
                $display("FAIL post_reset_idle: we=%b rst=%b, expected we=0 rst=1", we_bus, core_reset);
            else n_pass++;
        end
    endtask

    task automatic test_full_image();
        int exp_count; int exp_sum; int n; int cnt[4];
        logic [3:0] exp_we; logic [15:0] a; logic [7:0] d;
        exp_count = 0; exp_sum = 0; cnt = '{0, 0, 0, 0};
        dn_if.dn_download = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (core_reset !== 1'b1 || dl_done !== 1'b0 || dl_error !== 1'b0 || byte_count !== 17'd0)
            $display("FAIL full_start: rst=%b done=%b err=%b cnt=%0d, expected 1/0/0/0",
                     core_reset, dl_done, dl_error, byte_count);
        else n_pass++;
        for (int i = 0; i < TOTAL; i++) begin
            a = 16'(i); d = a[7:0];
            exp_we = ref_region(a);
            exp_count++; exp_sum += int'(d);
            drive_byte(a, d);
            n_checks++;
            if (we_bus !== exp_we || wr_addr !== ref_local(a) || wr_data !== d ||
                byte_count !== 17'(exp_count) || dl_error !== 1'b0)
                $display("FAIL full_byte a=%h: we=%b wa=%h wd=%h cnt=%0d err=%b, expected we=%b wa=%h wd=%h cnt=%0d err=0",
                         a, we_bus, wr_addr, wr_data, byte_count, dl_error, exp_we, ref_local(a), d, exp_count);
            else n_pass++;
            for (int r = 0; r < 4; r++) cnt[r] += int'(we_bus[r]);
            if (a == 16'h4001) begin
                n_checks++;
                if (we_bus !== 4'b0010 || wr_addr !== 14'd1 || wr_data !== 8'h01)
                    $display("FAIL char1_byte_4001: we=%b wa=%h wd=%h, expected we=0010 wa=0001 wd=01",
                             we_bus, wr_addr, wr_data);
                else n_pass++;
            end
        end
        n_checks++;
        if (cnt[0] != 16384 || cnt[1] != 4096 || cnt[2] != 4096 || cnt[3] != 512)
            $display("FAIL strobe_counts: prog=%0d char1=%0d char2=%0d prom=%0d, expected 16384/4096/4096/512",
                     cnt[0], cnt[1], cnt[2], cnt[3]);
        else n_pass++;
        dn_if.dn_download = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (core_reset !== 1'b1 || dl_done !== 1'b0 || dl_error !== 1'b0)
            $display("FAIL full_fall: rst=%b done=%b err=%b, expected 1/0/0", core_reset, dl_done, dl_error);
        else n_pass++;
        n = 0;
        while (core_reset === 1'b1 && n < 4 * HOLD_CYCLES) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n != HOLD_CYCLES)
            $display("FAIL hold_length: core_reset fell after %0d clocks, expected %0d", n, HOLD_CYCLES);
        else n_pass++;
        n_checks++;
        if (core_reset !== 1'b0 || dl_done !== 1'b1 || dl_error !== 1'b0 || byte_count !== 17'(TOTAL))
            $display("FAIL full_run: rst=%b done=%b err=%b cnt=%0d, expected 0/1/0/%0d",
                     core_reset, dl_done, dl_error, byte_count, TOTAL);
        else n_pass++;
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
        n_checks++;
        if (checksum !== 16'(exp_sum) || checksum !== EXP_SUM_FULL)
            $display("FAIL full_checksum: got %h, expected %h", checksum, 16'(exp_sum));
        else n_pass++;
`endif
    endtask

    task automatic test_ext_reset();
        int w; logic e;
        for (int k = 0; k < 3; k++) begin
            w = $urandom_range(1, 6);
            for (int i = 0; i < w + 3; i++) begin
                e = (i < w);
                ext_reset = e;
                @(posedge clk); #1;
                n_checks++;
                if (core_reset !== e || dl_done !== 1'b1)
                    $display("FAIL ext_reset pulse%0d step%0d: rst=%b done=%b, expected rst=%b done=1",
                             k, i, core_reset, dl_done, e);
                else n_pass++;
            end
        end
        ext_reset = 1'b0;
    endtask

    task automatic test_reload_short_image();
        int exp_count; logic [3:0] exp_we; logic [15:0] a; logic [7:0] d;
        exp_count = 0;
        dn_if.dn_download = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (dl_done !== 1'b0 || core_reset !== 1'b1 || byte_count !== 17'd0 || dl_error !== 1'b0)
            $display("FAIL reload_start: done=%b rst=%b cnt=%0d err=%b, expected 0/1/0/0",
                     dl_done, core_reset, byte_count, dl_error);
        else n_pass++;
        for (int i = 0; i < TOTAL - 1; i++) begin
            a = 16'(i); d = 8'($urandom);
            exp_we = ref_region(a);
            exp_count++;
            drive_byte(a, d);
            n_checks++;
            if (we_bus !== exp_we || wr_addr !== ref_local(a) || wr_data !== d || byte_count !== 17'(exp_count))
                $display("FAIL short_byte a=%h: we=%b wa=%h wd=%h cnt=%0d, expected we=%b wa=%h wd=%h cnt=%0d",
                         a, we_bus, wr_addr, wr_data, byte_count, exp_we, ref_local(a), d, exp_count);
            else n_pass++;
        end
        dn_if.dn_download = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (dl_error !== 1'b1 || core_reset !== 1'b1 || dl_done !== 1'b0 || byte_count !== 17'(TOTAL - 1))
            $display("FAIL short_end: err=%b rst=%b done=%b cnt=%0d, expected 1/1/0/%0d",
                     dl_error, core_reset, dl_done, byte_count, TOTAL - 1);
        else n_pass++;
        repeat (HOLD_CYCLES + 50) @(posedge clk);
        #1;
        n_checks++;
        if (core_reset !== 1'b1 || dl_done !== 1'b0 || dl_error !== 1'b1)
            $display("FAIL short_stays_reset: rst=%b done=%b err=%b, expected 1/0/1", core_reset, dl_done, dl_error);
        else n_pass++;
    endtask

`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
    task automatic test_checksum_mismatch();
        int exp_sum; int flip; logic [15:0] a; logic [7:0] d;
        exp_sum = 0;
        flip = $urandom_range(0, TOTAL - 1);
        dn_if.dn_download = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < TOTAL; i++) begin
            a = 16'(i); d = a[7:0] ^ ((i == flip) ? 8'h5A : 8'h00);
            exp_sum += int'(d);
            drive_byte(a, d);
            n_checks++;
            if (we_bus !== ref_region(a) || byte_count !== 17'(i + 1))
                $display("FAIL sum_byte a=%h: we=%b cnt=%0d, expected we=%b cnt=%0d",
                         a, we_bus, byte_count, ref_region(a), i + 1);
            else n_pass++;
        end
        dn_if.dn_download = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (checksum !== 16'(exp_sum) || dl_error !== 1'b1 || core_reset !== 1'b1)
            $display("FAIL sum_mismatch_end: sum=%h err=%b rst=%b, expected sum=%h err=1 rst=1",
                     checksum, dl_error, core_reset, 16'(exp_sum));
        else n_pass++;
        repeat (HOLD_CYCLES + 50) @(posedge clk);
        #1;
        n_checks++;
        if (core_reset !== 1'b1 || dl_done !== 1'b0)
            $display("FAIL sum_stays_reset: rst=%b done=%b, expected 1/0", core_reset, dl_done);
        else n_pass++;
    endtask
`else
    task automatic test_out_of_map();
        int exp_count; logic exp_err; logic [3:0] exp_we; logic [15:0] a; logic [7:0] d;
        exp_count = 0; exp_err = 1'b0;
        dn_if.dn_download = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (dl_error !== 1'b0 || byte_count !== 17'd0)
            $display("FAIL oom_start: err=%b cnt=%0d, expected 0/0", dl_error, byte_count);
        else n_pass++;
        for (int i = 0; i <= TOTAL; i++) begin
            if (i == 12288) a = 16'($urandom_range(32'h6200, 32'hFFFF));
            else            a = 16'((i < 12288) ? i : i - 1);
            d = 8'($urandom);
            exp_we = ref_region(a);
            if (exp_we != 4'b0) exp_count++;
            else                exp_err = 1'b1;
            drive_byte(a, d);
            n_checks++;
            if (we_bus !== exp_we || byte_count !== 17'(exp_count) || dl_error !== exp_err ||
                (exp_we != 4'b0 && (wr_addr !== ref_local(a) || wr_data !== d)))
                $display("FAIL oom_byte a=%h: we=%b wa=%h wd=%h cnt=%0d err=%b, expected we=%b wa=%h wd=%h cnt=%0d err=%b",
                         a, we_bus, wr_addr, wr_data, byte_count, dl_error,
                         exp_we, ref_local(a), d, exp_count, exp_err);
            else n_pass++;
        end
        dn_if.dn_download = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (byte_count !== 17'h06200 || dl_error !== 1'b1 || core_reset !== 1'b1 || dl_done !== 1'b0)
            $display("FAIL oom_end: cnt=%h err=%b rst=%b done=%b, expected 06200/1/1/0",
                     byte_count, dl_error, core_reset, dl_done);
        else n_pass++;
        repeat (HOLD_CYCLES + 50) @(posedge clk);
        #1;
        n_checks++;
        if (core_reset !== 1'b1 || dl_done !== 1'b0)
            $display("FAIL oom_stays_reset: rst=%b done=%b, expected 1/0", core_reset, dl_done);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_download();
        test_full_image();
        test_ext_reset();
        test_reload_short_image();
`ifdef PLEIADS_ROM_LOADER_CHECKSUM_EN
        test_checksum_mismatch();
`else
        test_out_of_map();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Time limit: the whole sequence needs well under this many clocks
    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
